// File: rtl/core_pkg.sv
// Shared definitions for the pipelined RV32I core.
//   XLEN        architectural width (32 only)
//   NOP_INS     canonical NOP (addi x0, x0, 0) injected for bubbles
//   OP_*        RV32I major opcodes used by the decode stage
//   hold_state_t  IF hold-buffer states
//   align_pc    clears the low two bits of a jump/branch target
package core_pkg;

    localparam int unsigned XLEN    = 32;
    localparam logic [31:0] NOP_INS = 32'h0000_0013;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic {
        RUN,
        HOLD
    } hold_state_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// Hold buffer for the IF/ID boundary.
// The instruction memory is synchronous, so its output moves on to the next
// word one cycle after a stall begins. This block captures the word on the
// first stalled cycle and replays it until the stall ends.
//   clk, rst     clock, synchronous active-high reset
//   stall        hazard hold request
//   redirect     EX redirect; discards any held word
//   id_valid     IF/ID valid flag; invalid slots present NOP
//   imem_rdata   synchronous memory read data
//   id_ins       instruction presented to ID
module if_hold_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic        id_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_ins
);
    import core_pkg::*;

    hold_state_t state_q;
    hold_state_t state_d;
    logic [31:0] hold_ins;
    logic        hold_valid;
    logic        capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            hold_ins <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                hold_ins <= imem_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            RUN: begin
                if (stall && !redirect) begin
                    state_d = HOLD;
                    capture = 1'b1;
                end
            end
            HOLD: begin
                if (!stall || redirect) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign hold_valid = (state_q == HOLD);

    always_comb begin
        id_ins = imem_rdata;
        if (!id_valid) begin
            id_ins = NOP_INS;
        end else if (hold_valid) begin
            id_ins = hold_ins;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID boundary of the RV32I pipeline.
// Owns the PC, addresses a synchronous instruction memory and presents the
// fetched word with its PC to ID. Priority per cycle: rst > redirect >
// stall > advance.
//   clk, rst     clock, synchronous active-high reset
//   stall        hold PC and IF/ID contents this cycle
//   redirect     refetch from redirect_pc (low two bits ignored)
//   imem_addr    fetch address (= PC register)
//   imem_rdata   memory word for the previous cycle's address
//   id_ins       instruction to ID (NOP when invalid)
//   id_pc/id_pc4 PC of id_ins and PC+4 for link values
//   id_valid     id_ins is a real on-path instruction; id_kill = ~id_valid
//   fetch_cnt    instructions handed from IF/ID to EX
module if_stage #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] id_ins,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc4,
    output logic            id_valid,
    output logic            id_kill,
    output logic [XLEN-1:0] fetch_cnt
);
    import core_pkg::*;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] id_pc_q;
    logic            id_valid_q;
    logic [XLEN-1:0] fetch_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            id_pc_q     <= '0;
            id_valid_q  <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            // An instruction leaves IF/ID only when it is valid and neither
            // held by a stall nor squashed by a redirect.
            if (id_valid_q && !stall && !redirect) begin
                fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
            end
            if (redirect) begin
                // The word the memory returns next cycle is wrong-path, so
                // the slot behind the redirect becomes a bubble.
                pc_q       <= align_pc(redirect_pc);
                id_valid_q <= 1'b0;
            end else if (!stall) begin
                id_pc_q    <= pc_q;
                id_valid_q <= 1'b1;
                pc_q       <= pc_q + XLEN'(4);
            end
        end
    end

    if_hold_buf u_hold_buf (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .id_valid   (id_valid_q),
        .imem_rdata (imem_rdata),
        .id_ins     (id_ins)
    );

    assign imem_addr = pc_q;
    assign id_pc     = id_pc_q;
    assign id_pc4    = id_pc_q + XLEN'(4);
    assign id_valid  = id_valid_q;
    assign id_kill   = ~id_valid_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic        kill;
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] addr;
        logic [31:0] cnt;
    } obs_t;

    typedef struct packed {
        logic        st;
        logic        rd;
        logic [31:0] rp;
        logic        r;
        obs_t        exp;
    } step_t;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_rdata, id_ins, id_pc, id_pc4, fetch_cnt;
    logic        id_valid, id_kill;

    logic        rst_w;
    logic        tie0 = 1'b0;
    logic [31:0] tie0_32 = '0;
    logic [31:0] imem_addr_w, imem_rdata_w, id_ins_w, id_pc_w, id_pc4_w, fetch_cnt_w;
    logic        id_valid_w, id_kill_w;

    int compared   = 0;
    int mismatched = 0;
    obs_t sb[$];

    always #5 clk = ~clk;

    if_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .id_ins(id_ins), .id_pc(id_pc), .id_pc4(id_pc4), .id_valid(id_valid),
        .id_kill(id_kill), .fetch_cnt(fetch_cnt)
    );

    if_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst_w), .stall(tie0), .redirect(tie0),
        .redirect_pc(tie0_32), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
        .id_ins(id_ins_w), .id_pc(id_pc_w), .id_pc4(id_pc4_w), .id_valid(id_valid_w),
        .id_kill(id_kill_w), .fetch_cnt(fetch_cnt_w)
    );

    // Memory contents: a distinct, non-NOP word per address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    initial begin
        imem_rdata   = '0;
        imem_rdata_w = '0;
    end
    always @(posedge clk) begin
        imem_rdata   <= memf(imem_addr);
        imem_rdata_w <= memf(imem_addr_w);
    end

    function automatic obs_t mk(input logic v, input logic [31:0] pc,
                                input logic [31:0] addr, input logic [31:0] cnt);
        obs_t o;
        o.valid = v;
        o.kill  = ~v;
        o.ins   = v ? memf(pc) : NOP;
        o.pc    = v ? pc : 32'h0;
        o.pc4   = v ? pc + 32'd4 : 32'h0;
        o.addr  = addr;
        o.cnt   = cnt;
        return o;
    endfunction

    function automatic step_t stp(input logic st, input logic rd, input logic [31:0] rp,
                                  input logic r, input obs_t e);
        step_t s;
        s.st = st; s.rd = rd; s.rp = rp; s.r = r; s.exp = e;
        return s;
    endfunction

    function automatic obs_t sample_main();
        obs_t o;
        o.valid = id_valid;
        o.kill  = id_kill;
        o.ins   = id_ins;
        o.pc    = id_valid ? id_pc : 32'h0;
        o.pc4   = id_valid ? id_pc4 : 32'h0;
        o.addr  = imem_addr;
        o.cnt   = fetch_cnt;
        return o;
    endfunction

    function automatic obs_t sample_wrap();
        obs_t o;
        o.valid = id_valid_w;
        o.kill  = id_kill_w;
        o.ins   = id_ins_w;
        o.pc    = id_valid_w ? id_pc_w : 32'h0;
        o.pc4   = id_valid_w ? id_pc4_w : 32'h0;
        o.addr  = imem_addr_w;
        o.cnt   = fetch_cnt_w;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("v=%b k=%b ins=%h pc=%h pc4=%h addr=%h cnt=%0d",
                         o.valid, o.kill, o.ins, o.pc, o.pc4, o.addr, o.cnt);
    endfunction

    // Drive one cycle of stimulus on the main DUT, record its expected
    // outcome and advance to just after the next rising edge.
    task automatic apply(input step_t s);
        stall       = s.st;
        redirect    = s.rd;
        redirect_pc = s.rp;
        rst         = s.r;
        sb.push_back(s.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rst_w = 1'b1;
        @(posedge clk); #1;
        sb.push_back(mk(1'b0, 32'h0, 32'h0, 32'd0));
        @(posedge clk); #1;
        got = sample_main();
        exp = sb.pop_front();
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL reset_state: got %s want %s", fmt(got), fmt(exp));
        end
        compared++;
        if (id_pc !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_id_pc: got %h want %h", id_pc, 32'h0);
        end
    endtask

    task automatic test_sequential();
        step_t s[$];
        obs_t got, exp;
        for (int k = 1; k <= 3; k++)
            s.push_back(stp(1'b0, 1'b0, '0, 1'b0, mk(1'b1, 32'(4*(k-1)), 32'(4*k), 32'(k-1))));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample_main();
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL sequential[%0d]: got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_stall();
        step_t s[$];
        obs_t got, exp;
        for (int k = 0; k < 3; k++)
            s.push_back(stp(1'b1, 1'b0, '0, 1'b0, mk(1'b1, 32'h8, 32'hC, 32'd2)));
        s.push_back(stp(1'b0, 1'b0, '0, 1'b0, mk(1'b1, 32'hC, 32'h10, 32'd3)));
        s.push_back(stp(1'b0, 1'b0, '0, 1'b0, mk(1'b1, 32'h10, 32'h14, 32'd4)));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample_main();
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL stall[%0d]: got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_redirect();
        step_t s[$];
        obs_t got, exp;
        s.push_back(stp(1'b0, 1'b1, 32'h103, 1'b0, mk(1'b0, 32'h0, 32'h100, 32'd4)));
        s.push_back(stp(1'b0, 1'b0, '0, 1'b0, mk(1'b1, 32'h100, 32'h104, 32'd4)));
        s.push_back(stp(1'b0, 1'b0, '0, 1'b0, mk(1'b1, 32'h104, 32'h108, 32'd5)));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample_main();
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL redirect[%0d]: got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_redirect_in_hold();
        step_t s[$];
        obs_t got, exp;
        s.push_back(stp(1'b1, 1'b0, '0, 1'b0, mk(1'b1, 32'h104, 32'h108, 32'd5)));
        s.push_back(stp(1'b1, 1'b1, 32'h200, 1'b0, mk(1'b0, 32'h0, 32'h200, 32'd5)));
        s.push_back(stp(1'b0, 1'b0, '0, 1'b0, mk(1'b1, 32'h200, 32'h204, 32'd5)));
        s.push_back(stp(1'b0, 1'b0, '0, 1'b0, mk(1'b1, 32'h204, 32'h208, 32'd6)));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample_main();
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL redirect_in_hold[%0d]: got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        obs_t got, exp;
        s.push_back(stp(1'b0, 1'b1, 32'h300, 1'b0, mk(1'b0, 32'h0, 32'h300, 32'd6)));
        s.push_back(stp(1'b0, 1'b1, 32'h402, 1'b0, mk(1'b0, 32'h0, 32'h400, 32'd6)));
        s.push_back(stp(1'b0, 1'b0, '0, 1'b0, mk(1'b1, 32'h400, 32'h404, 32'd6)));
        s.push_back(stp(1'b0, 1'b0, '0, 1'b0, mk(1'b1, 32'h404, 32'h408, 32'd7)));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample_main();
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL back_to_back[%0d]: got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_reset_mid_redirect();
        step_t s[$];
        obs_t got, exp;
        s.push_back(stp(1'b0, 1'b1, 32'h500, 1'b0, mk(1'b0, 32'h0, 32'h500, 32'd7)));
        s.push_back(stp(1'b1, 1'b0, '0, 1'b0, mk(1'b0, 32'h0, 32'h500, 32'd7)));
        s.push_back(stp(1'b1, 1'b0, '0, 1'b1, mk(1'b0, 32'h0, 32'h0, 32'd0)));
        s.push_back(stp(1'b0, 1'b0, '0, 1'b0, mk(1'b1, 32'h0, 32'h4, 32'd0)));
        s.push_back(stp(1'b0, 1'b0, '0, 1'b0, mk(1'b1, 32'h4, 32'h8, 32'd1)));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample_main();
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL reset_mid_redirect[%0d]: got %s want %s", i, fmt(got), fmt(exp));
            end
            if (i == 2) begin
                compared++;
                if (id_pc !== 32'h0) begin
                    mismatched++;
                    $display("FAIL reset_mid_redirect_id_pc: got %h want %h", id_pc, 32'h0);
                end
            end
        end
    endtask

    task automatic test_pc_wrap();
        obs_t exp_q[$];
        obs_t got, exp;
        // dut_wrap has been held in reset since time zero.
        got = sample_wrap();
        exp = mk(1'b0, 32'h0, 32'hFFFF_FFF8, 32'd0);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL pc_wrap_reset: got %s want %s", fmt(got), fmt(exp));
        end
        exp_q.push_back(mk(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'd0));
        exp_q.push_back(mk(1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'd1));
        exp_q.push_back(mk(1'b1, 32'h0000_0000, 32'h0000_0004, 32'd2));
        rst_w = 1'b0;
        foreach (exp_q[i]) begin
            sb.push_back(exp_q[i]);
            @(posedge clk); #1;
            got = sample_wrap();
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL pc_wrap[%0d]: got %s want %s", i, fmt(got), fmt(exp));
            end
        end
        compared++;
        if (id_pc4_w !== 32'h4) begin
            mismatched++;
            $display("FAIL pc_wrap_pc4_at_zero: got %h want %h", id_pc4_w, 32'h4);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        rst = 1'b0;
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_in_hold();
        test_back_to_back();
        test_reset_mid_redirect();
        test_pc_wrap();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
